// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM state encoding
// and the default widths / starvation threshold.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_RWAIT = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam int DM_AW_DEF       = 8;
    localparam int DM_DW_DEF       = 32;
    localparam int DM_MAX_WAIT_DEF = 15;
    localparam int WAIT_CNT_W      = 8;

endpackage

// File: rtl/dm_arb_wait_cnt.sv
// Saturating pending-cycle counter with threshold compare for the host
// starvation flag. Only part of the build when DM_ARB_STARVE_EN is defined.
`ifdef DM_ARB_STARVE_EN
module dm_arb_wait_cnt
    import dm_arb_pkg::*;
#(
    parameter int MAX_WAIT = DM_MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic reached_o
);

    localparam int                    THRESH_I = (MAX_WAIT > 255) ? 255 : MAX_WAIT;
    localparam logic [WAIT_CNT_W-1:0] THRESH   = THRESH_I[WAIT_CNT_W-1:0];

    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear outside PEND, otherwise count unissued cycles up to all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign reached_o = (cnt_q >= THRESH);

endmodule
`endif

// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: CPU strobes always own the RAM ports; a host
// request is latched and slotted into the first cycle its port is free.
// Optional feature macro: DM_ARB_STARVE_EN (host_starve flag + wait counter).
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int AW       = DM_AW_DEF,
    parameter int DW       = DM_DW_DEF,
    parameter int MAX_WAIT = DM_MAX_WAIT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_rden,
    input  logic [AW-1:0] cpu_rdaddr,
    output logic [DW-1:0] cpu_rdata,
    input  logic          cpu_wren,
    input  logic [AW-1:0] cpu_wraddr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          host_starve,
    output logic          busy,
    output logic          mem_rden,
    output logic [AW-1:0] mem_rdaddr,
    input  logic [DW-1:0] mem_q,
    output logic          mem_wren,
    output logic [AW-1:0] mem_wraddr,
    output logic [DW-1:0] mem_wdata
);

    if (MAX_WAIT < 1) begin : g_bad_max_wait
        $error("dm_port_arbiter: MAX_WAIT must be at least 1");
    end

    arb_state_e    state_q, state_d;
    logic          req_we_q, req_we_d;
    logic [AW-1:0] req_addr_q, req_addr_d;
    logic [DW-1:0] req_wdata_q, req_wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          wr_issue, rd_issue, rd_conflict;

    // FSM next state, request latch, read capture and issue decisions.
    always_comb begin
        state_d     = state_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        rdata_d     = rdata_q;
        wr_issue    = 1'b0;
        rd_issue    = 1'b0;
        // A CPU write to the address we want to read must land first.
        rd_conflict = cpu_wren && (cpu_wraddr == req_addr_q);
        case (state_q)
            ST_IDLE: begin
                if (host_req) begin
                    req_we_d    = host_we;
                    req_addr_d  = host_addr;
                    req_wdata_d = host_wdata;
                    state_d     = ST_PEND;
                end
            end
            ST_PEND: begin
                if (req_we_q) begin
                    if (!cpu_wren) begin
                        wr_issue = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end else if (!cpu_rden && !rd_conflict) begin
                    rd_issue = 1'b1;
                    state_d  = ST_RWAIT;
                end
            end
            ST_RWAIT: begin
                rdata_d = mem_q;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched request and host read data registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    // RAM port muxing: CPU first, then an issuing host access, else quiet.
    always_comb begin
        mem_rden   = 1'b0;
        mem_rdaddr = '0;
        mem_wren   = 1'b0;
        mem_wraddr = '0;
        mem_wdata  = '0;
        if (cpu_rden) begin
            mem_rden   = 1'b1;
            mem_rdaddr = cpu_rdaddr;
        end else if (rd_issue) begin
            mem_rden   = 1'b1;
            mem_rdaddr = req_addr_q;
        end
        if (cpu_wren) begin
            mem_wren   = 1'b1;
            mem_wraddr = cpu_wraddr;
            mem_wdata  = cpu_wdata;
        end else if (wr_issue) begin
            mem_wren   = 1'b1;
            mem_wraddr = req_addr_q;
            mem_wdata  = req_wdata_q;
        end
    end

    assign cpu_rdata   = mem_q;
    assign host_ack    = wr_issue | rd_issue;
    assign host_rvalid = (state_q == ST_RESP);
    assign host_rdata  = rdata_q;
    assign busy        = (state_q != ST_IDLE);

`ifdef DM_ARB_STARVE_EN
    logic wait_reached;

    dm_arb_wait_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_cnt (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (state_q != ST_PEND),
        .inc_i     ((state_q == ST_PEND) && !host_ack),
        .reached_o (wait_reached)
    );

    assign host_starve = (state_q == ST_PEND) && wait_reached;
`else
    assign host_starve = 1'b0;
`endif

endmodule
